// File: rtl/sine_pkg.sv
// Shared constants, channel encoding and phase-index wrap for the two-channel
// sine LUT scheduler.
package sine_pkg;

  localparam int DATA_W    = 24;
  localparam int LUT_DEPTH = 91;
  localparam int ADDR_W    = 7;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(LUT_DEPTH);

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_e;

  // One extra bit keeps idx+step from overflowing before the wrap compare.
  function automatic logic [ADDR_W-1:0] wrap_idx(input logic [ADDR_W-1:0] idx,
                                                 input logic [ADDR_W-1:0] step);
    logic [ADDR_W:0] sum;
    sum = {1'b0, idx} + {1'b0, step};
    if (sum >= DEPTH_W) sum = sum - DEPTH_W;
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sine_lut_scheduler_if.sv
// Scheduler-side bundle: control inputs, shared LUT port and the L/R sample streams.
interface sine_lut_scheduler_if;
  import sine_pkg::*;

  logic              enable;
  logic [ADDR_W-1:0] step_l;
  logic [ADDR_W-1:0] step_r;
  logic              lut_rd_en;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data;
  logic              l_valid;
  logic [DATA_W-1:0] l_data;
  logic              l_ready;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_ready;

  modport master (
    input  enable, step_l, step_r, lut_data, l_ready, r_ready,
    output lut_rd_en, lut_addr, l_valid, l_data, r_valid, r_data
  );

  modport slave (
    output enable, step_l, step_r, lut_data, l_ready, r_ready,
    input  lut_rd_en, lut_addr, l_valid, l_data, r_valid, r_data
  );

endinterface

// File: rtl/sine_chan_slot.sv
// Per-channel state: phase index, in-flight tags and the output sample register.
module sine_chan_slot
  import sine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] step,
  input  logic              grant,
  input  logic              tag,
  input  logic [DATA_W-1:0] lut_data,
  input  logic              ready,
  output logic              req,
  output logic [ADDR_W-1:0] idx,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic pending;
  logic cap;

  // Only fetch when the output slot will be free by the time the sample lands.
  assign req = enable && !pending && (!valid || ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      pending <= 1'b0;
      cap     <= 1'b0;
      valid   <= 1'b0;
      data    <= '0;
    end else begin
      if (grant) idx <= wrap_idx(idx, step);
      pending <= grant | (pending & ~cap);
      cap     <= tag;
      if (cap) begin
        data  <= lut_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sine_lut_scheduler.sv
// Round-robin sharing of one synchronous sine LUT between the L and R channels.
module sine_lut_scheduler
  import sine_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  sine_lut_scheduler_if.master        bus
);

  logic              req_l, req_r;
  logic              grant_l, grant_r;
  logic [ADDR_W-1:0] idx_l, idx_r;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  chan_e             rr_last;
  logic              tag_l, tag_r;

  always_comb begin
    grant_l = 1'b0;
    grant_r = 1'b0;
    if (req_l && (!req_r || rr_last == CH_R)) grant_l = 1'b1;
    else if (req_r)                           grant_r = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      rr_last <= CH_R;
    end else begin
      rd_en_q <= grant_l | grant_r;
      if (grant_l) begin
        addr_q  <= idx_l;
        rr_last <= CH_L;
      end else if (grant_r) begin
        addr_q  <= idx_r;
        rr_last <= CH_R;
      end
    end
  end

  // While a read is outstanding, rr_last still names the channel that issued it.
  assign tag_l = rd_en_q && (rr_last == CH_L);
  assign tag_r = rd_en_q && (rr_last == CH_R);

  assign bus.lut_rd_en = rd_en_q;
  assign bus.lut_addr  = addr_q;

  sine_chan_slot u_slot_l (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .step     (bus.step_l),
    .grant    (grant_l),
    .tag      (tag_l),
    .lut_data (bus.lut_data),
    .ready    (bus.l_ready),
    .req      (req_l),
    .idx      (idx_l),
    .valid    (bus.l_valid),
    .data     (bus.l_data)
  );

  sine_chan_slot u_slot_r (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .step     (bus.step_r),
    .grant    (grant_r),
    .tag      (tag_r),
    .lut_data (bus.lut_data),
    .ready    (bus.r_ready),
    .req      (req_r),
    .idx      (idx_r),
    .valid    (bus.r_valid),
    .data     (bus.r_data)
  );

endmodule

// File: tb/tb_sine_lut_scheduler.sv
// Scoreboard bench: per-channel expected index sequences vs. delivered samples
// with an identity ROM (sample value equals LUT index).
module tb_sine_lut_scheduler;
  import sine_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ql[$];
  int   qr[$];

  sine_lut_scheduler_if bus();

  sine_lut_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.lut_data <= {{(DATA_W-ADDR_W){1'b0}}, bus.lut_addr};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next index each channel will deliver: head of its queue, or 0 after reset.
  task automatic load_model(input int sl, input int sr, input bit from_reset);
    int bl, br;
    bl = (from_reset || ql.size() == 0) ? 0 : ql[0];
    br = (from_reset || qr.size() == 0) ? 0 : qr[0];
    ql.delete();
    qr.delete();
    for (int k = 0; k < 200; k++) begin
      ql.push_back(bl);
      qr.push_back(br);
      bl = (bl + sl) % LUT_DEPTH;
      br = (br + sr) % LUT_DEPTH;
    end
    bus.step_l = ADDR_W'(sl);
    bus.step_r = ADDR_W'(sr);
  endtask

  // Stop fetching, let in-flight reads land, then consume everything held.
  task automatic drain();
    bus.enable = 1'b0;
    repeat (6) tick();
    bus.l_ready = 1'b1;
    bus.r_ready = 1'b1;
    repeat (4) tick();
  endtask

  // Monitor: pops one expected sample per transfer and checks hold stability.
  logic              pv_l = 1'b0, px_l = 1'b0, pv_r = 1'b0, px_r = 1'b0;
  logic [DATA_W-1:0] pd_l = '0, pd_r = '0;

  always @(negedge clk) begin
    if (!reset) begin
      pv_l = 1'b0; px_l = 1'b0; pv_r = 1'b0; px_r = 1'b0;
    end else begin
      if (pv_l && !px_l) begin
        chk("l_hold_valid", longint'(bus.l_valid), 1);
        chk("l_hold_data", longint'(bus.l_data), longint'(pd_l));
      end
      if (pv_r && !px_r) begin
        chk("r_hold_valid", longint'(bus.r_valid), 1);
        chk("r_hold_data", longint'(bus.r_data), longint'(pd_r));
      end
      if (bus.l_valid && bus.l_ready) begin
        if (ql.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL l_data: got %0d, expected nothing (no sample due)", bus.l_data);
        end else chk("l_data", longint'(bus.l_data), longint'(ql.pop_front()));
      end
      if (bus.r_valid && bus.r_ready) begin
        if (qr.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL r_data: got %0d, expected nothing (no sample due)", bus.r_data);
        end else chk("r_data", longint'(bus.r_data), longint'(qr.pop_front()));
      end
      pv_l = bus.l_valid; px_l = bus.l_valid && bus.l_ready; pd_l = bus.l_data;
      pv_r = bus.r_valid; px_r = bus.r_valid && bus.r_ready; pd_r = bus.r_data;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, longint'(bus.lut_rd_en), 0);
    chk({tag, "_l_valid"}, longint'(bus.l_valid), 0);
    chk({tag, "_r_valid"}, longint'(bus.r_valid), 0);
    chk({tag, "_l_data"}, longint'(bus.l_data), 0);
    chk({tag, "_r_data"}, longint'(bus.r_data), 0);
  endtask

  initial begin
    bit seen;
    bus.enable  = 1'b0;
    bus.step_l  = '0;
    bus.step_r  = '0;
    bus.l_ready = 1'b0;
    bus.r_ready = 1'b0;

    // 1: reset with enable low, then release without spurious fetches
    repeat (10) tick();
    check_idle_outputs("reset");
    chk("reset_addr", longint'(bus.lut_addr), 0);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_release_rd_en", longint'(bus.lut_rd_en), 0);
    end

    // 2: L streams with step 1; R fetches once and holds sample 0
    load_model(1, 1, 1'b1);
    bus.l_ready = 1'b1;
    bus.r_ready = 1'b0;
    bus.enable  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 3) chk("l_latency", longint'(bus.l_valid), (c == 3) ? 1 : 0);
      if (c >= 3) chk("r_latency", longint'(bus.r_valid), (c == 4) ? 1 : 0);
    end
    repeat (290) tick();
    chk("r_held_valid", longint'(bus.r_valid), 1);
    chk("r_held_data", longint'(bus.r_data), 0);

    // 3: larger steps around the wrap
    drain();
    load_model(7, 1, 1'b0);
    bus.l_ready = 1'b1; bus.r_ready = 1'b0; bus.enable = 1'b1;
    repeat (60) tick();
    drain();
    load_model(10, 1, 1'b0);
    bus.l_ready = 1'b1; bus.r_ready = 1'b0; bus.enable = 1'b1;
    repeat (60) tick();

    // 4: both channels streaming step 1
    drain();
    load_model(1, 1, 1'b0);
    bus.l_ready = 1'b1; bus.r_ready = 1'b1; bus.enable = 1'b1;
    repeat (200) tick();

    // 5: L back-pressured for 20 cycles while R keeps running
    bus.l_ready = 1'b0;
    repeat (20) tick();
    chk("l_stalled_valid", longint'(bus.l_valid), 1);
    bus.l_ready = 1'b1;
    repeat (30) tick();

    // Randomised segments: random steps, readies and enable
    for (int s = 0; s < 5; s++) begin
      drain();
      load_model(int'($urandom_range(0, LUT_DEPTH-1)), int'($urandom_range(0, LUT_DEPTH-1)), 1'b0);
      bus.enable = 1'b1;
      for (int c = 0; c < 150; c++) begin
        tick();
        bus.l_ready = 1'($urandom_range(0, 1));
        bus.r_ready = 1'($urandom_range(0, 1));
        bus.enable  = ($urandom_range(0, 7) != 0);
      end
    end

    // 6: reset asserted the cycle after a LUT read strobe
    drain();
    load_model(3, 5, 1'b0);
    bus.l_ready = 1'b1; bus.r_ready = 1'b1; bus.enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.lut_rd_en) seen = 1'b1;
    end
    chk("rd_en_seen_before_reset", longint'(seen), 1);
    tick();
    reset = 1'b0;
    bus.enable = 1'b0;
    ql.delete();
    qr.delete();
    #1;
    check_idle_outputs("midfetch_reset");
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_idle_outputs("after_restart");
    end
    load_model(1, 1, 1'b1);
    bus.enable = 1'b1;
    repeat (60) tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
